// File: rtl/serial_bus_master.sv
// serial_bus_master: decodes 'W'/'R' byte frames into single 32-bit native-bus transactions, returns response bytes.
// Optional bus-wait timeout with ERR_BYTE response is enabled by defining SBM_TIMEOUT_EN.
module serial_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  ERR_BYTE       = 8'h45
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_e;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        op_wr_q, op_wr_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_hit;
  logic        resp_last;

`ifdef SBM_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_q, wait_d;

  // Counter sits at zero outside BUS, so it always starts from zero on BUS entry.
  always_comb begin
    wait_d = wait_q;
    if (state_q != S_BUS) begin
      wait_d = '0;
    end else if (!mem_ready) begin
      wait_d = wait_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign timeout_hit = (state_q == S_BUS) && !mem_ready && (wait_q == WAIT_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_wr_q <= op_wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Writes and errors answer with one byte; reads with four.
  assign resp_last = op_wr_q || err_q || (idx_q == 2'd3);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_wr_d = op_wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == OP_WR || rx_data == OP_RD)) begin
          op_wr_d = (rx_data == OP_WR);
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d = {rx_data, addr_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = op_wr_q ? S_DATA : S_BUS;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          wdata_d = {rx_data, wdata_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // mem_ready takes priority over a timeout landing in the same cycle.
        if (mem_ready) begin
          rdata_d = mem_rdata;
          idx_d   = '0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (resp_last) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_valid = (state_q == S_BUS);
    tx_valid  = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
    tx_data   = '0;
    if (state_q == S_RESP) begin
      if (err_q) begin
        tx_data = ERR_BYTE;
      end else if (op_wr_q) begin
        tx_data = ACK_BYTE;
      end else begin
        case (idx_q)
          2'd0:    tx_data = rdata_q[7:0];
          2'd1:    tx_data = rdata_q[15:8];
          2'd2:    tx_data = rdata_q[23:16];
          default: tx_data = rdata_q[31:24];
        endcase
      end
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = op_wr_q ? 4'hF : 4'h0;

endmodule

// File: tb/tb_serial_bus_master.sv
// Scoreboard bench for serial_bus_master: directed frames, expected bus requests and tx bytes queued at issue.
module tb_serial_bus_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  serial_bus_master #(
    .TIMEOUT_CYCLES(16),
    .ACK_BYTE(8'h4B),
    .ERR_BYTE(8'h45)
  ) dut (
    .clock(clock), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          chk_wdata;
    int          len;
  } bus_t;

  bus_t        busq[$];
  logic [7:0]  txq[$];
  int          errors = 0;
  int          checks = 0;
  int          rdy_delay = 0;
  logic [31:0] rdata_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                         input bit cw, input int len);
    bus_t b;
    b.addr = a; b.wdata = w; b.wstrb = s; b.chk_wdata = cw; b.len = len;
    busq.push_back(b);
  endtask

  task automatic exp_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) txq.push_back(w[8*i +: 8]);
  endtask

  // Called just after a rising edge; returns just after the edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [71:0] f, input int n);
    for (int i = 0; i < n; i++) send_byte(f[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (k < 3000 && (busy || txq.size() != 0 || busq.size() != 0)) begin
      @(posedge clock); #1;
      k++;
    end
    check(name, {31'd0, k < 3000}, 32'd1);
  endtask

  // Memory responder: raises mem_ready once rdy_delay request cycles have passed (never if negative).
  initial begin : responder
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (mem_valid && !mem_ready) begin
        if (rdy_delay >= 0 && wcnt >= rdy_delay) begin
          mem_ready = 1'b1;
          mem_rdata = rdata_val;
        end else begin
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin : bus_mon
    logic prev_mv;
    int   len;
    bus_t cur;
    prev_mv = 1'b0;
    len = 0;
    cur.addr = '0; cur.wdata = '0; cur.wstrb = '0; cur.chk_wdata = 1'b0; cur.len = -1;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_mv = 1'b0;
        continue;
      end
      if (mem_valid && !prev_mv) begin
        len = 1;
        if (busq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got request addr %h, none expected", mem_addr);
          cur.len = -1;
        end else begin
          cur = busq.pop_front();
          check("bus_addr", mem_addr, cur.addr);
          check("bus_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
          if (cur.chk_wdata) check("bus_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_valid) begin
        len++;
        check("bus_hold_addr", mem_addr, cur.addr);
      end else if (prev_mv) begin
        if (cur.len > 0) check("bus_len", len, cur.len);
        check("tx_after_bus", {31'd0, tx_valid}, 32'd1);
      end
      prev_mv = mem_valid;
    end
  end

  initial begin : tx_mon
    logic       stalled;
    logic [7:0] held;
    logic       busy_due;
    logic [7:0] e;
    stalled = 1'b0;
    busy_due = 1'b0;
    held = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stalled = 1'b0;
        busy_due = 1'b0;
        continue;
      end
      if (busy_due) begin
        check("busy_after_resp", {31'd0, busy}, 32'd0);
        busy_due = 1'b0;
      end
      if (stalled) begin
        check("tx_stall_valid", {31'd0, tx_valid}, 32'd1);
        check("tx_stall_data", {24'd0, tx_data}, {24'd0, held});
      end
      stalled = 1'b0;
      if (tx_valid) begin
        check("no_mv_with_tx", {31'd0, mem_valid}, 32'd0);
        if (tx_ready) begin
          if (txq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte %h, none expected", tx_data);
          end else begin
            e = txq.pop_front();
            check("tx_byte", {24'd0, tx_data}, {24'd0, e});
            if (txq.size() == 0) busy_due = 1'b1;
          end
        end else begin
          stalled = 1'b1;
          held = tx_data;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Write, mem_ready one cycle into the request.
    rdy_delay = 1;
    exp_bus(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1, 2);
    txq.push_back(8'h4B);
    send_frame(72'h57_00_10_00_00_EF_BE_AD_DE, 9);
    check("wr_mv_latency", {31'd0, mem_valid}, 32'd1);
    wait_idle("wr_done");

    // Read with address low bits set and a 3-cycle tx stall.
    rdy_delay = 0;
    rdata_val = 32'h1234_5678;
    tx_ready = 1'b0;
    exp_bus(32'h0000_1000, 32'h0, 4'h0, 1'b0, 1);
    exp_word(32'h1234_5678);
    send_frame(72'h52_03_10_00_00, 5);
    check("rd_mv_latency", {31'd0, mem_valid}, 32'd1);
    k = 0;
    while (!tx_valid && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    check("rd_tx_seen", {31'd0, tx_valid}, 32'd1);
    repeat (3) @(posedge clock);
    #1;
    tx_ready = 1'b1;
    wait_idle("rd_done");

    // Junk bytes in IDLE are discarded.
    send_byte(8'h00);
    check("junk00_busy", {31'd0, busy}, 32'd0);
    send_byte(8'hFF);
    check("junkFF_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h41);
    check("junk41_busy", {31'd0, busy}, 32'd0);
    check("junk_no_mv", {31'd0, mem_valid}, 32'd0);
    rdata_val = 32'hA5A5_0F0F;
    exp_bus(32'h8000_0020, 32'h0, 4'h0, 1'b0, 1);
    exp_word(32'hA5A5_0F0F);
    send_byte(8'h52);
    check("junk_R_busy", {31'd0, busy}, 32'd1);
    send_frame(72'h22_00_00_80, 4);
    wait_idle("junk_rd_done");

`ifdef SBM_TIMEOUT_EN
    // Responder never answers: 16 request cycles, then ERR_BYTE.
    rdy_delay = -1;
    exp_bus(32'h0000_0004, 32'h4433_2211, 4'hF, 1'b1, 16);
    txq.push_back(8'h45);
    send_frame(72'h57_04_00_00_00_11_22_33_44, 9);
    wait_idle("timeout_done");
    rdy_delay = 0;
`else
    // Without a timeout the request simply waits.
    rdy_delay = -1;
    exp_bus(32'h0000_0004, 32'h4433_2211, 4'hF, 1'b1, -1);
    txq.push_back(8'h4B);
    send_frame(72'h57_04_00_00_00_11_22_33_44, 9);
    repeat (1000) @(posedge clock);
    #1;
    check("longwait_mv", {31'd0, mem_valid}, 32'd1);
    check("longwait_no_tx", {31'd0, tx_valid}, 32'd0);
    rdy_delay = 0;
    wait_idle("longwait_done");
`endif

    // Reset mid-frame discards the partial frame.
    send_frame(72'h57_00_10, 3);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_mv", {31'd0, mem_valid}, 32'd0);
    rdata_val = 32'hCAFE_F00D;
    exp_bus(32'h0000_0008, 32'h0, 4'h0, 1'b0, 1);
    exp_word(32'hCAFE_F00D);
    send_frame(72'h52_08_00_00_00, 5);
    wait_idle("midrst_rd_done");

    // rx bytes during a stalled BUS are dropped.
    rdy_delay = -1;
    rdata_val = 32'h0BAD_F00D;
    exp_bus(32'h0000_0040, 32'h0, 4'h0, 1'b0, -1);
    exp_word(32'h0BAD_F00D);
    send_frame(72'h52_40_00_00_00, 5);
    send_frame(72'h57_52_AA, 3);
    check("drop_mv_held", {31'd0, mem_valid}, 32'd1);
    rdy_delay = 0;
    wait_idle("drop_rd_done");
    rdy_delay = 1;
    exp_bus(32'h0000_0044, 32'h0403_0201, 4'hF, 1'b1, 2);
    txq.push_back(8'h4B);
    send_frame(72'h57_44_00_00_00_01_02_03_04, 9);
    wait_idle("drop_wr_done");

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_bus_master.md
# serial_bus_master

Byte-stream-driven initiator for the native PicoRV32 memory bus (mem_valid/mem_ready handshake), the counterpart of the peripheral responders on that bus. It decodes read/write command frames from a received byte stream, such as the simpleuart receive side, and issues single 32-bit bus transactions. It returns a response frame on a transmit byte stream. It sits beside the CPU behind a bus arbiter and is used for host-side debug and memory load.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum wait-for-mem_ready cycles; range 2..65535; used only with SBM_TIMEOUT_EN.
- ACK_BYTE, 8'h4B: write-acknowledge response byte.
- ERR_BYTE, 8'h45: bus-error response byte.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_valid  out  1  response byte available.
- tx_data  out  8  response byte.
- tx_ready  in  1  consumer accepts tx_data when tx_valid && tx_ready.
- mem_valid  out  1  bus request.
- mem_addr  out  32  word address; bits [1:0] always 0.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'hF for a write, 4'h0 for a read.
- mem_ready  in  1  responder completion.
- mem_rdata  in  32  read data; valid when mem_ready is high.
- busy  out  1  high in every state except IDLE.

## Operation
- Write frame: 8'h57 ('W'), 4 address bytes LSB first, 4 data bytes LSB first. Response: ACK_BYTE.
- Read frame: 8'h52 ('R'), 4 address bytes LSB first. Response: 4 data bytes, LSB first.
- In IDLE, any byte other than 'W' or 'R' is discarded silently.
- States:
  - IDLE: on 'R' or 'W', latch the opcode, clear the byte index, go to ADDR.
  - ADDR: shift in 4 bytes. After the 4th byte, go to DATA if the opcode is 'W', otherwise go to BUS.
  - DATA: shift in 4 bytes, then go to BUS.
  - BUS: hold mem_valid and all bus outputs stable until mem_ready. Capture mem_rdata on the mem_ready cycle, then go to RESP.
  - RESP: send 1 byte (write, or error) or 4 bytes (read), then go to IDLE.
- A 2-bit byte index is used in ADDR, DATA and RESP. It wraps 3 -> 0 on state exit.
- The address is forced to word alignment: the received bits [1:0] are ignored and mem_addr[1:0] = 0.
- rx_valid strobes that arrive in BUS or RESP are dropped. They are not queued, and the frame parser restarts in IDLE.
- Reset values: mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, tx_valid 0, tx_data 0, busy 0; state IDLE.

## Timing
- If the final command byte is strobed in cycle N, mem_valid is high from cycle N+1.
- mem_ready sampled high in cycle M:
  - mem_valid is low in cycle M+1.
  - tx_valid is high in cycle M+1 with the first response byte.
- A response byte is held stable while tx_valid && !tx_ready.
- After a handshake in cycle K, the next byte is presented in cycle K+1, so tx_valid may stay high back-to-back.
- After the last response handshake, busy is low in the following cycle. A new opcode is accepted in that same cycle.
- mem_valid is never asserted in the same cycle as tx_valid.
- Best-case latency for a read, with mem_ready in the first request cycle: 1 cycle from the last rx byte to mem_valid, then 1 cycle to tx_valid.
- Reset mid-operation: on the next edge, return to IDLE and drop mem_valid and tx_valid. Any partial frame or pending response is discarded.

## Configuration
- SBM_TIMEOUT_EN defined:
  - A 16-bit wait counter clears when BUS is entered and increments each cycle mem_valid && !mem_ready.
  - If the count reaches TIMEOUT_CYCLES-1 without mem_ready, mem_valid drops on the next edge and the response is the single byte ERR_BYTE, for both reads and writes.
  - If mem_ready is high in the terminal-count cycle, mem_ready wins and a normal response is sent.
- SBM_TIMEOUT_EN undefined: no counter; BUS waits for mem_ready indefinitely; ERR_BYTE is never emitted.

## Test plan
- Write: feed 57 00 10 00 00 EF BE AD DE; mem_ready one cycle after mem_valid. Expect:
  - mem_addr 32'h0000_1000, mem_wdata 32'hDEAD_BEEF, mem_wstrb 4'hF, with mem_valid high for exactly 2 cycles;
  - then a single tx byte 8'h4B.
- Read with tx backpressure: feed 52 03 10 00 00; mem_rdata 32'h1234_5678; tx_ready low for 3 cycles, then high. Expect:
  - mem_addr 32'h0000_1000 (low bits masked), mem_wstrb 4'h0;
  - tx bytes 78 56 34 12, with tx_data stable during the stall.
- Junk filtering: feed 00 FF 41 before a valid 'R' frame. Expect no bus activity and busy staying 0 until the 52 byte arrives; then a normal read.
- Timeout, with SBM_TIMEOUT_EN and TIMEOUT_CYCLES=16; write frame with mem_ready held low. Expect:
  - mem_valid high for exactly 16 cycles;
  - tx byte 8'h45;
  - busy low after the handshake.
  - Without the macro, mem_valid stays high for 1000 cycles.
- Reset mid-frame: assert reset for 1 cycle after 57 00 10. Expect:
  - busy 0 on the next cycle;
  - a following complete 'R' frame is decoded correctly, with no stale address bytes.
- Dropped rx: strobe 3 bytes during a stalled BUS state. Expect them to be ignored; the response is unchanged and the next frame parses normally.
